mult_result_display: RTL and testbench

- Downstream stage of the 4×4 combinational multiplier.
- Captures the 8-bit product `resu` on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the multiplier output and the board display pins.

---
 rtl/mult_result_display.sv | 149 ++++++++++++++
 tb/tb_mult_result_display.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mult_result_display.sv
// Captures the 8-bit multiplier product, converts it to BCD with a sequential double-dabble
// FSM, and scans it onto a 4-digit common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module mult_result_display #(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  resu,
  input  logic        cargar,
  output logic        ocupado,
  output logic        listo,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              sr_q, sr_d;
  logic [11:0]             scratch_q, scratch_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [11:0]             bcd_q, bcd_d;
  logic                    listo_q, listo_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]              idx_q, idx_d;

  logic [11:0] adj;
  logic [3:0]  digit;
  logic        blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      listo_q   <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      listo_q   <= listo_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
    end
  end

  // Add-3 correction applied to each scratch nibble before the shift
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    listo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cargar) begin
          sr_d      = resu;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, sr_d} = {adj[10:0], sr_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7)
          state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan index steps on the edge after the refresh counter reaches all-ones
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    idx_d     = idx_q;
    if (refresh_q == '1)
      idx_d = idx_q + 2'd1;
  end

  always_comb begin
    digit = 4'hF;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = bcd_q[3:0];
      2'd1: begin
        digit = bcd_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        digit = bcd_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_q[11:8] == 4'd0);
`endif
      end
      default: blank = 1'b1;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0: seg = 7'b0000001;
        4'd1: seg = 7'b1001111;
        4'd2: seg = 7'b0010010;
        4'd3: seg = 7'b0000110;
        4'd4: seg = 7'b1001100;
        4'd5: seg = 7'b0100100;
        4'd6: seg = 7'b0100000;
        4'd7: seg = 7'b0001111;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0000100;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign an      = ~(4'b0001 << idx_q);
  assign dp      = 1'b1;
  assign ocupado = (state_q != IDLE);
  assign listo   = listo_q;
  assign bcd     = bcd_q;

endmodule

// File: tb/tb_mult_result_display.sv
// Directed bench for mult_result_display with a 2-bit refresh counter (4 cycles per digit).
module tb_mult_result_display;

  logic        clk;
  logic        rst;
  logic [7:0]  resu;
  logic        cargar;
  logic        ocupado;
  logic        listo;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  mult_result_display #(.REFRESH_BITS(2)) dut (
    .clk(clk), .rst(rst), .resu(resu), .cargar(cargar), .ocupado(ocupado),
    .listo(listo), .bcd(bcd), .seg(seg), .an(an), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive a one-cycle load strobe; returns at the negedge after the accepting edge
  task automatic start_load(input logic [7:0] v);
    @(negedge clk);
    resu   = v;
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cargar = 1'b0; resu = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++; if (bcd !== 12'h000) begin nerr++; $display("FAIL reset_bcd got %h want 000", bcd); end
    nvec++; if (an !== 4'b1110) begin nerr++; $display("FAIL reset_an got %b want 1110", an); end
    nvec++; if (seg !== 7'b0000001) begin nerr++; $display("FAIL reset_seg got %b want 0000001", seg); end
    nvec++; if (ocupado !== 1'b0) begin nerr++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    nvec++; if (listo !== 1'b0) begin nerr++; $display("FAIL reset_listo got %b want 0", listo); end
    nvec++; if (dp !== 1'b1) begin nerr++; $display("FAIL reset_dp got %b want 1", dp); end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    start_load(8'd54);
    for (int i = 0; i < 9; i++) begin
      nvec++;
      if (ocupado !== 1'b1 || listo !== 1'b0) begin
        nerr++; $display("FAIL nominal_busy cycle %0d got ocupado=%b listo=%b want 1/0", i, ocupado, listo);
      end
      @(negedge clk);
    end
    nvec++; if (listo !== 1'b1 || ocupado !== 1'b0) begin nerr++; $display("FAIL nominal_listo got listo=%b ocupado=%b want 1/0", listo, ocupado); end
    nvec++; if (bcd !== 12'h054) begin nerr++; $display("FAIL nominal_bcd got %h want 054", bcd); end
    @(negedge clk);
    nvec++; if (listo !== 1'b0) begin nerr++; $display("FAIL nominal_pulse got listo=%b want 0", listo); end
  endtask

  task automatic test_max_scan;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    bit ok;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0100100;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b0010010;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0010010;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111111;
    start_load(8'd225);
    repeat (9) @(negedge clk);
    nvec++; if (listo !== 1'b1 || bcd !== 12'h225) begin nerr++; $display("FAIL max_bcd got listo=%b bcd=%h want 1/225", listo, bcd); end
    wait_an(4'b0111, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL max_sync0 got an=%b want 0111", an); end
    wait_an(4'b1110, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL max_sync1 got an=%b want 1110", an); end
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (an !== exp_an[d] || seg !== exp_seg[d]) begin
          nerr++; $display("FAIL max_scan digit %0d cycle %0d got an=%b seg=%b want %b/%b", d, k, an, seg, exp_an[d], exp_seg[d]);
        end
        @(negedge clk);
      end
    end
    nvec++; if (an !== 4'b1110) begin nerr++; $display("FAIL max_wrap got an=%b want 1110", an); end
  endtask

  task automatic test_busy_ignore;
    int unsigned pulses;
    start_load(8'd200);
    repeat (2) @(negedge clk);
    resu = 8'd17; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (listo === 1'b1) pulses++;
      @(negedge clk);
    end
    nvec++; if (pulses != 1) begin nerr++; $display("FAIL busy_pulses got %0d want 1", pulses); end
    nvec++; if (bcd !== 12'h200) begin nerr++; $display("FAIL busy_bcd got %h want 200", bcd); end
    nvec++; if (ocupado !== 1'b0) begin nerr++; $display("FAIL busy_idle got ocupado=%b want 0", ocupado); end
  endtask

  task automatic test_back_to_back;
    start_load(8'd150);
    repeat (9) @(negedge clk);
    nvec++; if (listo !== 1'b1 || bcd !== 12'h150) begin nerr++; $display("FAIL b2b_first got listo=%b bcd=%h want 1/150", listo, bcd); end
    resu = 8'd99; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    nvec++; if (ocupado !== 1'b1) begin nerr++; $display("FAIL b2b_accept got ocupado=%b want 1", ocupado); end
    repeat (9) @(negedge clk);
    nvec++; if (listo !== 1'b1 || bcd !== 12'h099) begin nerr++; $display("FAIL b2b_second got listo=%b bcd=%h want 1/099", listo, bcd); end
  endtask

  task automatic test_abort;
    int unsigned pulses;
    start_load(8'd255);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++; if (bcd !== 12'h000 || ocupado !== 1'b0) begin nerr++; $display("FAIL abort_state got bcd=%h ocupado=%b want 000/0", bcd, ocupado); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (listo === 1'b1) pulses++;
      @(negedge clk);
    end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL abort_listo got %0d pulses want 0", pulses); end
    start_load(8'd255);
    repeat (9) @(negedge clk);
    nvec++; if (listo !== 1'b1 || bcd !== 12'h255) begin nerr++; $display("FAIL abort_restart got listo=%b bcd=%h want 1/255", listo, bcd); end
  endtask

  task automatic test_blanking;
    logic [6:0] lead;
    bit ok;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 7'b1111111;
`else
    lead = 7'b0000001;
`endif
    start_load(8'd7);
    repeat (9) @(negedge clk);
    nvec++; if (bcd !== 12'h007) begin nerr++; $display("FAIL blank_bcd got %h want 007", bcd); end
    wait_an(4'b1110, ok);
    nvec++; if (!ok || seg !== 7'b0001111) begin nerr++; $display("FAIL blank_units got an=%b seg=%b want 1110/0001111", an, seg); end
    wait_an(4'b1101, ok);
    nvec++; if (!ok || seg !== lead) begin nerr++; $display("FAIL blank_tens got an=%b seg=%b want 1101/%b", an, seg, lead); end
    wait_an(4'b1011, ok);
    nvec++; if (!ok || seg !== lead) begin nerr++; $display("FAIL blank_hundreds got an=%b seg=%b want 1011/%b", an, seg, lead); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_max_scan;
    test_busy_ignore;
    test_back_to_back;
    test_abort;
    test_blanking;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
